fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32 core. Holds the program counter and drives the instruction-memory address. Latches the fetched instruction into IF/ID. Consumes the branch unit's taken/redirect decision (`PCsrc`) and target from EX, squashing wrong-path instructions and counting redirects for performance monitoring.

---
 rtl/fetch_stage.sv | 76 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32 instruction-fetch stage with PC register, IF/ID pipeline
//               register, branch redirect squash and redirect counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        PCsrc,
    input  logic [31:0] branchTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pcPlus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        flushIDEX,
    output logic [31:0] redirectCount
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pcplus4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_redirect_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + c_PC_STEP;
    // jalr targets may have bit 0 set; fetch addresses are always halfword aligned
    assign w_target   = {branchTarget[31:1], 1'b0};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_ifid_pc        <= 32'd0;
            r_ifid_pcplus4   <= 32'd0;
            r_ifid_instr     <= NOP;
            r_ifid_valid     <= 1'b0;
            r_redirect_count <= 32'd0;
        end else if (PCsrc) begin
            // IF/ID PC fields hold; only the instruction slot is squashed
            r_pc             <= w_target;
            r_ifid_instr     <= NOP;
            r_ifid_valid     <= 1'b0;
            r_redirect_count <= r_redirect_count + 32'd1;
        end else if (!stall) begin
            r_pc             <= w_pc_plus4;
            r_ifid_pc        <= r_pc;
            r_ifid_pcplus4   <= w_pc_plus4;
            r_ifid_instr     <= imemData;
            r_ifid_valid     <= 1'b1;
        end
    end

    assign imemAddr      = r_pc;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pcPlus4  = r_ifid_pcplus4;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_valid    = r_ifid_valid;
    assign redirectCount = r_redirect_count;
    // Ungated on purpose: ID/EX has its own reset and must see every redirect
    assign flushIDEX     = PCsrc;

endmodule
`default_nettype wire
